// File: rtl/led_pkg.sv
// Shared definitions for led_pattern_gen: channel mode encoding, the config record
// carried through the shadow slot, and the channel-select width helper.
package led_pkg;

   localparam int CFG_CH_W    = 3;
   localparam int CFG_FIELD_W = 16;

   typedef enum logic [1:0] {
      MODE_OFF     = 2'd0,
      MODE_ON      = 2'd1,
      MODE_BLINK   = 2'd2,
      MODE_BREATHE = 2'd3
   } led_mode_e;

   // Fields are sized for the largest supported build (8 channels, 16-bit half/duty).
   typedef struct packed {
      logic [CFG_CH_W-1:0]    ch;
      led_mode_e              mode;
      logic [CFG_FIELD_W-1:0] half;
      logic [CFG_FIELD_W-1:0] duty;
   } led_cfg_t;

   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: holds mode/duty/half, the blink phase and half counter, and a registered led bit.
// With LED_BREATHE_EN defined, a per-channel level/direction ramp drives BREATHE; otherwise BREATHE acts as ON.
module led_channel
   import led_pkg::*;
#(
   parameter int PERIOD_W = 12,
   parameter int PWM_W    = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   tick,
   input  logic [PWM_W-1:0]       pwm_cnt,
   input  logic                   apply,
   input  led_mode_e              cfg_mode,
   input  logic [CFG_FIELD_W-1:0] cfg_half,
   input  logic [CFG_FIELD_W-1:0] cfg_duty,
   output logic                   led
);

   localparam logic [PERIOD_W-1:0] HALF_MAX = '1;
   localparam logic [PWM_W-1:0]    DUTY_MAX = '1;

   led_mode_e           mode_q, mode_d;
   logic [PWM_W-1:0]    duty_q, duty_d;
   logic [PERIOD_W-1:0] half_q, half_d;
   logic [PERIOD_W-1:0] half_cnt_q, half_cnt_d;
   logic                phase_q, phase_d;
   logic                led_q, led_d;
   logic [PWM_W-1:0]    bright;

`ifdef LED_BREATHE_EN
   logic [PWM_W-1:0]    level_q, level_d;
   logic                down_q, down_d;
`endif

   // A zero half-period runs as one tick; oversized fields clamp to this channel's width.
   always_comb begin
      mode_d     = mode_q;
      duty_d     = duty_q;
      half_d     = half_q;
      phase_d    = phase_q;
      half_cnt_d = half_cnt_q;
      if (apply) begin
         mode_d = cfg_mode;
         if (cfg_duty > CFG_FIELD_W'(DUTY_MAX)) begin
            duty_d = DUTY_MAX;
         end else begin
            duty_d = cfg_duty[PWM_W-1:0];
         end
         if (cfg_half == '0) begin
            half_d = PERIOD_W'(1);
         end else if (cfg_half > CFG_FIELD_W'(HALF_MAX)) begin
            half_d = HALF_MAX;
         end else begin
            half_d = cfg_half[PERIOD_W-1:0];
         end
         phase_d    = 1'b1;
         half_cnt_d = '0;
      end else if (tick) begin
         if (half_cnt_q == half_q - 1'b1) begin
            phase_d    = ~phase_q;
            half_cnt_d = '0;
         end else begin
            half_cnt_d = half_cnt_q + 1'b1;
         end
      end
   end

`ifdef LED_BREATHE_EN
   always_comb begin
      level_d = level_q;
      down_d  = down_q;
      if (apply) begin
         level_d = '0;
         down_d  = 1'b0;
      end else if (tick) begin
         if (!down_q) begin
            if (level_q >= duty_q) begin
               down_d = 1'b1;
               if (level_q != '0) begin
                  level_d = level_q - 1'b1;
               end
            end else begin
               level_d = level_q + 1'b1;
            end
         end else begin
            if (level_q == '0) begin
               down_d = 1'b0;
               if (duty_q != '0) begin
                  level_d = level_q + 1'b1;
               end
            end else begin
               level_d = level_q - 1'b1;
            end
         end
      end
   end
`endif

   always_comb begin
      bright = duty_q;
`ifdef LED_BREATHE_EN
      if (mode_q == MODE_BREATHE) begin
         bright = level_q;
      end
`endif
      led_d = 1'b0;
      case (mode_q)
         MODE_OFF:              led_d = 1'b0;
         MODE_ON, MODE_BREATHE: led_d = (pwm_cnt < bright);
         MODE_BLINK:            led_d = phase_q & (pwm_cnt < bright);
         default:               led_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q     <= MODE_OFF;
         duty_q     <= '0;
         half_q     <= PERIOD_W'(1);
         half_cnt_q <= '0;
         phase_q    <= 1'b1;
         led_q      <= 1'b0;
`ifdef LED_BREATHE_EN
         level_q    <= '0;
         down_q     <= 1'b0;
`endif
      end else begin
         mode_q     <= mode_d;
         duty_q     <= duty_d;
         half_q     <= half_d;
         half_cnt_q <= half_cnt_d;
         phase_q    <= phase_d;
         led_q      <= led_d;
`ifdef LED_BREATHE_EN
         level_q    <= level_d;
         down_q     <= down_d;
`endif
      end
   end

   assign led = led_q;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: tick prescaler, shared PWM counter and a single-slot config shadow.
// Define LED_BREATHE_EN to build the BREATHE ramp in each channel; without it mode 3 behaves as ON.
module led_pattern_gen
   import led_pkg::*;
#(
   parameter int  NUM_CH   = 3,
   parameter int  CLK_HZ   = 12_000_000,
   parameter int  TICK_HZ  = 1000,
   parameter int  PERIOD_W = 12,
   parameter int  PWM_W    = 8,
   localparam int CH_W     = ch_width(NUM_CH)
) (
   input  logic                clk_12mhz,
   input  logic                rst_n,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CH_W-1:0]     cfg_ch,
   input  logic [1:0]          cfg_mode,
   input  logic [PERIOD_W-1:0] cfg_half,
   input  logic [PWM_W-1:0]    cfg_duty,
   output logic                tick_o,
   output logic [NUM_CH-1:0]   led
);

   localparam int               DIV      = CLK_HZ / TICK_HZ;
   localparam int               PRE_W    = $clog2(DIV);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

   logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
   logic [PWM_W-1:0]  pwm_cnt_q, pwm_cnt_d;
   logic              pending_q, pending_d;
   led_cfg_t          shadow_q, shadow_d;
   logic              tick;
   logic              accept;
   logic              apply;
   logic [NUM_CH-1:0] ch_apply;

   always_comb begin
      tick      = (pre_cnt_q == PRE_LAST);
      pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
      pwm_cnt_d = pwm_cnt_q + 1'b1;
   end

   // Apply keys off the registered pending flag, so a request accepted on a tick waits for the next one.
   always_comb begin
      cfg_ready = ~pending_q;
      accept    = cfg_valid & ~pending_q;
      apply     = pending_q & tick;
      pending_d = pending_q;
      shadow_d  = shadow_q;
      if (apply) begin
         pending_d = 1'b0;
      end
      if (accept) begin
         pending_d     = 1'b1;
         shadow_d.ch   = CFG_CH_W'(cfg_ch);
         shadow_d.mode = led_mode_e'(cfg_mode);
         shadow_d.half = CFG_FIELD_W'(cfg_half);
         shadow_d.duty = CFG_FIELD_W'(cfg_duty);
      end
   end

   always_ff @(posedge clk_12mhz or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt_q <= '0;
         pwm_cnt_q <= '0;
         pending_q <= 1'b0;
         shadow_q  <= '0;
      end else begin
         pre_cnt_q <= pre_cnt_d;
         pwm_cnt_q <= pwm_cnt_d;
         pending_q <= pending_d;
         shadow_q  <= shadow_d;
      end
   end

   // An out-of-range channel number matches no instance and is silently dropped.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign ch_apply[i] = apply & (shadow_q.ch == CFG_CH_W'(i));

      led_channel #(
         .PERIOD_W (PERIOD_W),
         .PWM_W    (PWM_W)
      ) u_ch (
         .clk      (clk_12mhz),
         .rst_n    (rst_n),
         .tick     (tick),
         .pwm_cnt  (pwm_cnt_q),
         .apply    (ch_apply[i]),
         .cfg_mode (shadow_q.mode),
         .cfg_half (shadow_q.half),
         .cfg_duty (shadow_q.duty),
         .led      (led[i])
      );
   end

   assign tick_o = tick;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen: directed then randomized config traffic, checked each cycle
// against a reference model that derives LED state from tick counts since each channel's apply.
module tb_led_pattern_gen;

   localparam int NUM_CH   = 3;
   localparam int CLK_HZ   = 1000;
   localparam int TICK_HZ  = 100;
   localparam int PERIOD_W = 4;
   localparam int PWM_W    = 4;
   localparam int DIV      = CLK_HZ / TICK_HZ;
   localparam int PWM_MOD  = 1 << PWM_W;

   typedef struct {
      int led;
      int tick;
      int ready;
      int cyc;
   } exp_t;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                cfg_valid;
   logic                cfg_ready;
   logic [1:0]          cfg_ch;
   logic [1:0]          cfg_mode;
   logic [PERIOD_W-1:0] cfg_half;
   logic [PWM_W-1:0]    cfg_duty;
   logic                tick_o;
   logic [NUM_CH-1:0]   led;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   int   t;
   bit   pending;
   bit   accepted_now;
   int   sh_ch, sh_mode, sh_half, sh_duty;
   int   ch_mode[NUM_CH];
   int   ch_duty[NUM_CH];
   int   ch_half[NUM_CH];
   int   ch_ta[NUM_CH];
   int   led_exp;

   led_pattern_gen #(
      .NUM_CH   (NUM_CH),
      .CLK_HZ   (CLK_HZ),
      .TICK_HZ  (TICK_HZ),
      .PERIOD_W (PERIOD_W),
      .PWM_W    (PWM_W)
   ) dut (
      .clk_12mhz (clk),
      .rst_n     (rst_n),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_mode  (cfg_mode),
      .cfg_half  (cfg_half),
      .cfg_duty  (cfg_duty),
      .tick_o    (tick_o),
      .led       (led)
   );

   always #5 clk = ~clk;

   // Number of tick cycles in [0, x].
   function automatic int ticks_upto(input int x);
      return (x < 0) ? 0 : (x + 1) / DIV;
   endfunction

   function automatic int triangle(input int n, input int peak);
      int k;
      if (peak == 0) return 0;
      k = n % (2 * peak);
      return (k <= peak) ? k : 2 * peak - k;
   endfunction

   // LED compare result for channel c during cycle s; it appears on the pin in cycle s+1.
   function automatic int expected_bit(input int c, input int s);
      int pwm, n, hp, lvl;
      pwm = s % PWM_MOD;
      n   = ticks_upto(s - 1) - ticks_upto(ch_ta[c]);
      hp  = (ch_half[c] == 0) ? 1 : ch_half[c];
      lvl = ch_duty[c];
`ifdef LED_BREATHE_EN
      if (ch_mode[c] == 3) lvl = triangle(n, ch_duty[c]);
`endif
      case (ch_mode[c])
         1:       return (pwm < ch_duty[c]) ? 1 : 0;
         2:       return (((n / hp) % 2 == 0) && (pwm < ch_duty[c])) ? 1 : 0;
         3:       return (pwm < lvl) ? 1 : 0;
         default: return 0;
      endcase
   endfunction

   task automatic model_reset();
      t       = 0;
      pending = 1'b0;
      led_exp = 0;
      for (int c = 0; c < NUM_CH; c++) begin
         ch_mode[c] = 0;
         ch_duty[c] = 0;
         ch_half[c] = 1;
         ch_ta[c]   = 0;
      end
   endtask

   task automatic model_cycle();
      exp_t e;
      int   nxt;
      bit   tk;
      tk      = ((t % DIV) == DIV - 1);
      e.led   = led_exp;
      e.tick  = tk ? 1 : 0;
      e.ready = pending ? 0 : 1;
      e.cyc   = t;
      exp_q.push_back(e);
      nxt = 0;
      for (int c = 0; c < NUM_CH; c++) begin
         nxt = nxt | (expected_bit(c, t) << c);
      end
      if (tk && pending) begin
         pending = 1'b0;
         if (sh_ch < NUM_CH) begin
            ch_mode[sh_ch] = sh_mode;
            ch_duty[sh_ch] = sh_duty;
            ch_half[sh_ch] = sh_half;
            ch_ta[sh_ch]   = t;
         end
      end else if (cfg_valid && !pending) begin
         pending      = 1'b1;
         accepted_now = 1'b1;
         sh_ch        = int'(cfg_ch);
         sh_mode      = int'(cfg_mode);
         sh_half      = int'(cfg_half);
         sh_duty      = int'(cfg_duty);
      end
      led_exp = nxt;
      t++;
   endtask

   task automatic check_output(input string name, input int cyc, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("[TB] FAIL %s cycle=%0d got=%0d want=%0d", name, cyc, got, want);
      end
   endtask

   task automatic step_cycle();
      model_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      cfg_valid = 1'b0;
      repeat (n) step_cycle();
   endtask

   task automatic apply_stimulus(input int ch, input int mode, input int half, input int duty);
      int waited;
      cfg_valid    = 1'b1;
      cfg_ch       = 2'(ch);
      cfg_mode     = 2'(mode);
      cfg_half     = PERIOD_W'(half);
      cfg_duty     = PWM_W'(duty);
      accepted_now = 1'b0;
      waited       = 0;
      while (!accepted_now && waited < 40) begin
         step_cycle();
         waited++;
      end
      cfg_valid = 1'b0;
   endtask

   task automatic do_reset(input int cycles);
      exp_t e;
      cfg_valid = 1'b0;
      rst_n     = 1'b0;
      #1;
      check_output("rst_led", -1, int'(led), 0);
      check_output("rst_tick", -1, int'(tick_o), 0);
      check_output("rst_ready", -1, int'(cfg_ready), 1);
      @(posedge clk);
      #1;
      repeat (cycles) begin
         e.led   = 0;
         e.tick  = 0;
         e.ready = 1;
         e.cyc   = -1;
         exp_q.push_back(e);
         @(posedge clk);
         #1;
      end
      rst_n = 1'b1;
      model_reset();
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check_output("led", e.cyc, int'(led), e.led);
         check_output("tick_o", e.cyc, int'(tick_o), e.tick);
         check_output("cfg_ready", e.cyc, int'(cfg_ready), e.ready);
      end
   end

   initial begin
      rst_n     = 1'b1;
      cfg_valid = 1'b0;
      cfg_ch    = '0;
      cfg_mode  = '0;
      cfg_half  = '0;
      cfg_duty  = '0;
      #2;
      do_reset(3);

      $display("[TB] directed sequence");
      idle(3);
      apply_stimulus(0, 1, 0, 4);
      idle(8);
      apply_stimulus(1, 2, 3, 15);
      idle(16);
      apply_stimulus(2, 1, 5, 7);
      idle(15);
      apply_stimulus(3, 1, 1, 9);
      apply_stimulus(2, 3, 2, 4);
      idle(200);
      do_reset(2);

      $display("[TB] randomized sequence");
      for (int r = 0; r < 150; r++) begin
         idle(int'($urandom_range(0, 12)));
         apply_stimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
         if (r == 75) begin
            idle(int'($urandom_range(5, 40)));
            do_reset(2);
         end
      end
      idle(60);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
